// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared arbiter state and grant encodings plus the default read value
package wb_arb_pkg;
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_GNT0 = 2'd1;
  localparam logic [1:0] ARB_GNT1 = 2'd2;
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0 = 2'b01;
  localparam logic [1:0] GRANT_M1 = 2'b10;
  localparam logic [31:0] DEFAULT_READ_VALUE = 32'hBADFABAC;
endpackage

// File: rtl/wb_arb_timeout_cntr.sv
// wb_arb_timeout_cntr: counts unacked strobe cycles and forces a one-cycle ack at the limit
module wb_arb_timeout_cntr #(
  parameter int TIMEOUT_CNTR_WIDTH = 3,
  parameter int TIMEOUT_CYCLES = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic act,
  input  logic ack,
  input  logic idle,
  output logic forced_ack,
  output logic timeout
);
  logic [TIMEOUT_CNTR_WIDTH-1:0] cnt_q, cnt_d;
  assign forced_ack = act & (cnt_q == TIMEOUT_CNTR_WIDTH'(TIMEOUT_CYCLES));
  assign timeout = forced_ack;
  always_comb cnt_d = (idle | ack | forced_ack) ? '0 : act ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/wb_two_master_arbiter.sv
// wb_two_master_arbiter: round-robin two-master Wishbone arbiter; WB_ARB_TIMEOUT_EN adds a forced-ack bus timeout
module wb_two_master_arbiter #(
  parameter int ADDRWIDTH = 17,
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT_CNTR_WIDTH = 3,
  parameter int TIMEOUT_CYCLES = 7,
  parameter logic [DATAWIDTH-1:0] DEFAULT_READ_VALUE = wb_arb_pkg::DEFAULT_READ_VALUE
) (
  input  logic                 WB_CLK,
  input  logic                 WB_RST,
  input  logic [ADDRWIDTH-1:0] M0_ADR,
  input  logic                 M0_CYC,
  input  logic                 M0_STB,
  input  logic                 M0_WE,
  input  logic [3:0]           M0_BYTE_STB,
  input  logic [DATAWIDTH-1:0] M0_WR_DAT,
  output logic [DATAWIDTH-1:0] M0_RD_DAT,
  output logic                 M0_ACK,
  input  logic [ADDRWIDTH-1:0] M1_ADR,
  input  logic                 M1_CYC,
  input  logic                 M1_STB,
  input  logic                 M1_WE,
  input  logic [3:0]           M1_BYTE_STB,
  input  logic [DATAWIDTH-1:0] M1_WR_DAT,
  output logic [DATAWIDTH-1:0] M1_RD_DAT,
  output logic                 M1_ACK,
  output logic [ADDRWIDTH-1:0] S_ADR,
  output logic                 S_CYC,
  output logic                 S_STB,
  output logic                 S_WE,
  output logic [3:0]           S_BYTE_STB,
  output logic [DATAWIDTH-1:0] S_WR_DAT,
  input  logic [DATAWIDTH-1:0] S_RD_DAT,
  input  logic                 S_ACK,
  output logic [1:0]           Grant_o,
  output logic                 Timeout_o
);
  import wb_arb_pkg::ARB_IDLE;
  import wb_arb_pkg::ARB_GNT0;
  import wb_arb_pkg::ARB_GNT1;
  import wb_arb_pkg::GRANT_NONE;
  import wb_arb_pkg::GRANT_M0;
  import wb_arb_pkg::GRANT_M1;
  logic [1:0] state_q, state_d;
  logic last_grant_q, last_grant_d, g0, g1, forced_ack;
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= 2 ** TIMEOUT_CNTR_WIDTH) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit in TIMEOUT_CNTR_WIDTH bits");
  end
  always_ff @(posedge WB_CLK) begin
    state_q <= WB_RST ? ARB_IDLE : state_d;
    last_grant_q <= WB_RST ? 1'b1 : last_grant_d;
  end
  always_comb begin
    state_d = state_q == ARB_GNT0 ? (M0_CYC ? ARB_GNT0 : ARB_IDLE) :
              state_q == ARB_GNT1 ? (M1_CYC ? ARB_GNT1 : ARB_IDLE) :
              M0_CYC & (~M1_CYC | last_grant_q) ? ARB_GNT0 :
              M1_CYC ? ARB_GNT1 : ARB_IDLE;
    last_grant_d = (state_q != ARB_GNT0 && state_q != ARB_GNT1 && state_d != ARB_IDLE) ?
                   state_d == ARB_GNT1 : last_grant_q;
  end
  assign g0 = state_q == ARB_GNT0;
  assign g1 = state_q == ARB_GNT1;
  always_comb begin
    S_CYC = g0 ? M0_CYC : g1 & M1_CYC;
    S_STB = g0 ? M0_STB : g1 & M1_STB;
    S_WE = g0 ? M0_WE : g1 & M1_WE;
    S_ADR = g0 ? M0_ADR : g1 ? M1_ADR : '0;
    S_BYTE_STB = g0 ? M0_BYTE_STB : g1 ? M1_BYTE_STB : '0;
    S_WR_DAT = g0 ? M0_WR_DAT : g1 ? M1_WR_DAT : '0;
    Grant_o = g1 ? GRANT_M1 : g0 ? GRANT_M0 : GRANT_NONE;
  end
  // a late slave ack in the forced-ack cycle wins, so its data is returned
  assign M0_ACK = g0 & (S_ACK | forced_ack);
  assign M1_ACK = g1 & (S_ACK | forced_ack);
  assign M0_RD_DAT = g0 & ~(forced_ack & ~S_ACK) ? S_RD_DAT : DEFAULT_READ_VALUE;
  assign M1_RD_DAT = g1 & ~(forced_ack & ~S_ACK) ? S_RD_DAT : DEFAULT_READ_VALUE;
`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_timeout_cntr #(
    .TIMEOUT_CNTR_WIDTH(TIMEOUT_CNTR_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk(WB_CLK),
    .rst(WB_RST),
    .act(S_CYC & S_STB),
    .ack(S_ACK),
    .idle(~(g0 | g1)),
    .forced_ack(forced_ack),
    .timeout(Timeout_o)
  );
`else
  assign forced_ack = 1'b0;
  assign Timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_wb_two_master_arbiter.sv
// tb_wb_two_master_arbiter: directed stimulus checked every cycle against an ownership-level arbiter model
module tb_wb_two_master_arbiter;
  localparam logic [31:0] DEF = 32'hBADFABAC;
  localparam int TOC = 7;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] m_cyc = '0, m_stb = '0, m_we = '0, m_ack;
  logic [16:0] m_adr [2];
  logic [3:0] m_bs [2];
  logic [31:0] m_wd [2], m_rd [2];
  logic [16:0] s_adr;
  logic s_cyc, s_stb, s_we, to, s_ack = 1'b0;
  logic [3:0] s_bs;
  logic [31:0] s_wd, s_rd = '0;
  logic [1:0] grant;
  int n_run = 0, n_fail = 0;
  bit mdl_on = 0, has = 0, who = 0, last = 1;
  int stall = 0;
  wb_two_master_arbiter dut (
    .WB_CLK(clk), .WB_RST(rst),
    .M0_ADR(m_adr[0]), .M0_CYC(m_cyc[0]), .M0_STB(m_stb[0]), .M0_WE(m_we[0]),
    .M0_BYTE_STB(m_bs[0]), .M0_WR_DAT(m_wd[0]), .M0_RD_DAT(m_rd[0]), .M0_ACK(m_ack[0]),
    .M1_ADR(m_adr[1]), .M1_CYC(m_cyc[1]), .M1_STB(m_stb[1]), .M1_WE(m_we[1]),
    .M1_BYTE_STB(m_bs[1]), .M1_WR_DAT(m_wd[1]), .M1_RD_DAT(m_rd[1]), .M1_ACK(m_ack[1]),
    .S_ADR(s_adr), .S_CYC(s_cyc), .S_STB(s_stb), .S_WE(s_we), .S_BYTE_STB(s_bs),
    .S_WR_DAT(s_wd), .S_RD_DAT(s_rd), .S_ACK(s_ack), .Grant_o(grant), .Timeout_o(to)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit forced();
    return TO_EN && has && m_cyc[who] && m_stb[who] && stall == TOC;
  endfunction
  always @(posedge clk) begin
    bit f, nw;
    if (rst) begin
      mdl_on <= 1; has <= 0; last <= 1; stall <= 0;
    end else begin
      f = forced();
      stall <= (!has || f || s_ack) ? 0 : (m_cyc[who] && m_stb[who]) ? stall + 1 : stall;
      if (has) has <= m_cyc[who];
      else if (|m_cyc) begin
        nw = (&m_cyc) ? !last : m_cyc[1];
        who <= nw; has <= 1; last <= nw;
      end
    end
  end
  always @(negedge clk) if (mdl_on) begin
    bit f;
    f = forced();
    chk("grant", 32'(grant), has ? (who ? 32'd2 : 32'd1) : 32'd0);
    chk("s_cyc", 32'(s_cyc), 32'(has && m_cyc[who]));
    chk("s_stb", 32'(s_stb), 32'(has && m_stb[who]));
    chk("s_we", 32'(s_we), 32'(has && m_we[who]));
    chk("s_adr", 32'(s_adr), has ? 32'(m_adr[who]) : 32'd0);
    chk("s_bs", 32'(s_bs), has ? 32'(m_bs[who]) : 32'd0);
    chk("s_wd", s_wd, has ? m_wd[who] : 32'd0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m%0d_ack", i), 32'(m_ack[i]), 32'(has && who == i && (s_ack || f)));
      chk($sformatf("m%0d_rd", i), m_rd[i], (has && who == i && !(f && !s_ack)) ? s_rd : DEF);
    end
    chk("timeout", 32'(to), 32'(f));
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic req(input int i, input bit c, input bit s, input bit w, input logic [16:0] a, input logic [31:0] d);
    m_cyc[i] = c; m_stb[i] = s; m_we[i] = w; m_adr[i] = a; m_wd[i] = d; m_bs[i] = c ? 4'hF : 4'h0;
  endtask
  initial begin
    for (int i = 0; i < 2; i++) req(i, 0, 0, 0, '0, '0);
    tick(2);
    rst = 0;
    chk("lit_rst_grant", 32'(grant), 32'h0);
    chk("lit_rst_scyc", 32'(s_cyc), 32'h0);
    chk("lit_rst_timeout", 32'(to), 32'h0);
    // M0 alone writes, slave acks on the third strobe cycle
    req(0, 1, 1, 1, 17'h0000C, 32'h12345678);
    tick;
    chk("lit_t1_grant", 32'(grant), 32'h1);
    chk("lit_t1_wd", s_wd, 32'h12345678);
    chk("lit_t1_adr", 32'(s_adr), 32'hC);
    tick(2);
    s_ack = 1; #1;
    chk("lit_t1_m0ack", 32'(m_ack[0]), 32'h1);
    chk("lit_t1_m1ack", 32'(m_ack[1]), 32'h0);
    tick;
    s_ack = 0; req(0, 0, 0, 0, '0, '0);
    tick(2);
    // simultaneous requests after reset: M0, turnaround, M1, then M0 again
    rst = 1; tick; rst = 0;
    req(0, 1, 1, 0, 17'h1, '0); req(1, 1, 1, 0, 17'h2, '0);
    tick;
    chk("lit_t2_first", 32'(grant), 32'h1);
    s_ack = 1; s_rd = 32'h11110000;
    tick;
    s_ack = 0; req(0, 0, 0, 0, '0, '0);
    tick;
    chk("lit_t2_turn", 32'(grant), 32'h0);
    tick;
    chk("lit_t2_second", 32'(grant), 32'h2);
    s_ack = 1;
    tick;
    s_ack = 0; req(1, 0, 0, 0, '0, '0);
    tick;
    req(0, 1, 1, 0, 17'h3, '0); req(1, 1, 1, 0, 17'h4, '0);
    tick;
    chk("lit_t2_third", 32'(grant), 32'h1);
    s_ack = 1;
    tick;
    s_ack = 0; req(0, 0, 0, 0, '0, '0); req(1, 0, 0, 0, '0, '0);
    tick(2);
    // M1 three-beat burst with M0 arriving mid-burst
    req(1, 1, 1, 0, 17'h100, '0);
    tick;
    s_ack = 1; s_rd = 32'hA0;
    tick;
    s_rd = 32'hA1; req(0, 1, 1, 0, 17'h200, '0); #1;
    chk("lit_t3_m0ack", 32'(m_ack[0]), 32'h0);
    chk("lit_t3_m0rd", m_rd[0], 32'hBADFABAC);
    chk("lit_t3_m1rd", m_rd[1], 32'hA1);
    tick;
    s_rd = 32'hA2;
    tick;
    s_ack = 0; req(1, 0, 0, 0, '0, '0);
    tick;
    chk("lit_t3_idle", 32'(grant), 32'h0);
    tick;
    chk("lit_t3_m0gnt", 32'(grant), 32'h1);
    s_ack = 1;
    tick;
    s_ack = 0; req(0, 0, 0, 0, '0, '0);
    tick(2);
    // M0 read to a slave that never responds
    rst = 1; tick; rst = 0;
    req(0, 1, 1, 0, 17'h40, '0);
    tick;
`ifdef WB_ARB_TIMEOUT_EN
    tick(6);
    chk("lit_t4_c7_to", 32'(to), 32'h0);
    chk("lit_t4_c7_ack", 32'(m_ack[0]), 32'h0);
    tick;
    chk("lit_t4_c8_ack", 32'(m_ack[0]), 32'h1);
    chk("lit_t4_c8_rd", m_rd[0], 32'hBADFABAC);
    chk("lit_t4_c8_to", 32'(to), 32'h1);
    tick;
    chk("lit_t4_c9_to", 32'(to), 32'h0);
    chk("lit_t4_c9_ack", 32'(m_ack[0]), 32'h0);
    tick(7);
    s_ack = 1; s_rd = 32'hCAFE0002; #1;
    chk("lit_t4_late_ack", 32'(m_ack[0]), 32'h1);
    chk("lit_t4_late_rd", m_rd[0], 32'hCAFE0002);
`else
    tick(20);
    chk("lit_t5_noack", 32'(m_ack[0]), 32'h0);
    chk("lit_t5_to", 32'(to), 32'h0);
    s_ack = 1; s_rd = 32'hCAFE0001; #1;
    chk("lit_t5_ack", 32'(m_ack[0]), 32'h1);
    chk("lit_t5_rd", m_rd[0], 32'hCAFE0001);
`endif
    tick;
    s_ack = 0; req(0, 0, 0, 0, '0, '0);
    tick(2);
    // reset while M1 holds the bus mid-strobe
    req(1, 1, 1, 1, 17'h300, 32'h55);
    tick;
    chk("lit_t6_gnt1", 32'(grant), 32'h2);
    tick;
    rst = 1;
    tick;
    chk("lit_t6_grant", 32'(grant), 32'h0);
    chk("lit_t6_scyc", 32'(s_cyc), 32'h0);
    chk("lit_t6_m1ack", 32'(m_ack[1]), 32'h0);
    rst = 0; req(1, 0, 0, 0, '0, '0); req(0, 1, 1, 0, 17'h8, '0);
    tick;
    chk("lit_t6_m0gnt", 32'(grant), 32'h1);
    req(0, 0, 0, 0, '0, '0);
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
